bus_uart: RTL and testbench

- Memory-mapped 8N1 UART peripheral on the CPU's word-addressed data bus; downstream consumer of the core's bus_addr / bus_data_w / bus_mask_w / bus_write.
- Top-level muxes rdata into the core's bus_data_r when hit=1.
- Holds a 16-entry TX FIFO, a bit-serial transmitter and receiver, and a one-byte RX holding register.
- Read path is combinational, so the core's next-cycle-after-address load timing is met.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 54 +++++
 rtl/bus_uart.sv | 238 +++++++++++++++++++++++
 tb/tb_bus_uart.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state type and divisor helper for bus_uart
//   Register offsets (bus_addr[1:0]), STATUS bit positions, TX/RX FSM state enum,
//   and eff_div() which clamps the programmed divisor to the minimum bit length.
package uart_pkg;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DIVISOR = 2'd2;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_VALID = 2;
   localparam int ST_RX_OVR   = 3;
   localparam int ST_TX_OVF   = 4;
   localparam int ST_TX_BUSY  = 5;
   localparam int ST_RX_FERR  = 6;

   localparam logic [15:0] MIN_DIV = 16'd4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_t;

   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div < MIN_DIV) ? MIN_DIV : div;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with first-word-fall-through read data
//   clock, reset   : system clock, asynchronous active-low reset
//   i_push, i_data : write request and data (accepted when not full, or when popping)
//   i_pop          : read request (ignored when empty)
//   o_data         : head entry, valid whenever o_empty is low
//   o_full, o_empty, o_count : occupancy status
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push_ok;
   logic             w_pop_ok;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_count   = r_wr_ptr - r_rd_ptr;
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

   assign w_pop_ok  = i_pop & ~o_empty;
   // A pop on the same edge frees the slot the push lands in.
   assign w_push_ok = i_push & (~o_full | w_pop_ok);

   always_ff @(posedge clock) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/bus_uart.sv
// rtl/bus_uart.sv - memory-mapped 8N1 UART with TX FIFO and one-byte RX holding register
//   clock, reset : system clock, asynchronous active-low reset
//   bus_addr     : word address; hit when [31:2] matches BASE_WORD, [1:0] selects register
//   bus_data_w, bus_mask_w, bus_write : write data, byte-lane enables, write strobe
//   rdata, hit   : combinational read data (0 when not hit) and address match
//   uart_tx      : serial output, idle high
//   uart_rx      : asynchronous serial input
module bus_uart
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_WORD  = 32'h0C00_0000,
   parameter int          CLK_DIV    = 434,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_data_w,
   input  logic [3:0]  bus_mask_w,
   input  logic        bus_write,
   output logic [31:0] rdata,
   output logic        hit,
   output logic        uart_tx,
   input  logic        uart_rx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          w_hit, w_wr, w_data_wr, w_status_wr, w_rx_pop, w_drop;
   logic [1:0]    w_off;
   logic          w_full, w_empty, w_tx_pop, w_tx_done, w_rx_half, w_rx_done;
   logic [7:0]    w_fifo_data;
   logic [CW-1:0] w_count;
   logic [31:0]   w_status, w_rdata;
   logic          w_unused;

   logic [15:0]   r_divisor;
   logic          r_tx_ovf;
   uart_state_t   r_tx_state, r_rx_state;
   logic [15:0]   r_tx_cnt, r_tx_div, r_rx_cnt, r_rx_div;
   logic [2:0]    r_tx_bit, r_rx_bit;
   logic [7:0]    r_tx_shift, r_rx_shift, r_rx_byte;
   logic          r_uart_tx, r_rx_s1, r_rx_s2;
   logic          r_rx_valid, r_rx_ovr, r_rx_ferr;

   assign w_unused    = &{bus_data_w[31:16], bus_mask_w[3:2]};

   assign w_hit       = (bus_addr[31:2] == BASE_WORD[31:2]);
   assign w_off       = bus_addr[1:0];
   assign w_wr        = w_hit & bus_write;
   assign w_data_wr   = w_wr && (w_off == REG_DATA) && bus_mask_w[0];
   assign w_status_wr = w_wr && (w_off == REG_STATUS) && bus_mask_w[0];
   assign w_rx_pop    = w_status_wr & bus_data_w[ST_RX_VALID];
   assign w_drop      = w_data_wr & w_full & ~w_tx_pop;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_data_wr),
      .i_data  (bus_data_w[7:0]),
      .i_pop   (w_tx_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_divisor <= 16'(CLK_DIV);
         r_tx_ovf  <= 1'b0;
      end else begin
         if (w_wr && (w_off == REG_DIVISOR)) begin
            if (bus_mask_w[0]) r_divisor[7:0]  <= bus_data_w[7:0];
            if (bus_mask_w[1]) r_divisor[15:8] <= bus_data_w[15:8];
         end
         if (w_drop)                                     r_tx_ovf <= 1'b1;
         else if (w_status_wr && bus_data_w[ST_TX_OVF])  r_tx_ovf <= 1'b0;
      end
   end

   // ---------------- transmitter ----------------
   // The divisor is re-latched at every bit boundary so a new value applies from the next bit.
   assign w_tx_done = (r_tx_cnt == r_tx_div - 16'd1);
   assign w_tx_pop  = ~w_empty && ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && w_tx_done));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_tx_state <= S_IDLE;
         r_tx_cnt   <= '0;
         r_tx_div   <= MIN_DIV;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_uart_tx  <= 1'b1;
      end else if (r_tx_state == S_IDLE) begin
         if (w_tx_pop) begin
            r_tx_state <= S_START;
            r_tx_shift <= w_fifo_data;
            r_uart_tx  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_div   <= eff_div(r_divisor);
         end
      end else if (!w_tx_done) begin
         r_tx_cnt <= r_tx_cnt + 16'd1;
      end else begin
         r_tx_cnt <= '0;
         r_tx_div <= eff_div(r_divisor);
         case (r_tx_state)
            S_START: begin
               r_tx_state <= S_DATA;
               r_tx_bit   <= '0;
               r_uart_tx  <= r_tx_shift[0];
               r_tx_shift <= r_tx_shift >> 1;
            end
            S_DATA: begin
               if (r_tx_bit == 3'd7) begin
                  r_tx_state <= S_STOP;
                  r_uart_tx  <= 1'b1;
               end else begin
                  r_tx_bit   <= r_tx_bit + 3'd1;
                  r_uart_tx  <= r_tx_shift[0];
                  r_tx_shift <= r_tx_shift >> 1;
               end
            end
            default: begin
               // Back-to-back frames: go straight from stop to the next start bit.
               if (w_tx_pop) begin
                  r_tx_state <= S_START;
                  r_tx_shift <= w_fifo_data;
                  r_uart_tx  <= 1'b0;
               end else begin
                  r_tx_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   // ---------------- receiver ----------------
   assign w_rx_half = (r_rx_cnt == (r_rx_div >> 1) - 16'd1);
   assign w_rx_done = (r_rx_cnt == r_rx_div - 16'd1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_state <= S_IDLE;
         r_rx_cnt   <= '0;
         r_rx_div   <= MIN_DIV;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         r_rx_byte  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_ovr   <= 1'b0;
         r_rx_ferr  <= 1'b0;
      end else begin
         r_rx_s1 <= uart_rx;
         r_rx_s2 <= r_rx_s1;
         // Software pop/clear first; a frame completing on the same edge overrides below.
         if (w_rx_pop)                                    r_rx_valid <= 1'b0;
         if (w_status_wr && bus_data_w[ST_RX_OVR])        r_rx_ovr   <= 1'b0;
         if (w_status_wr && bus_data_w[ST_RX_FERR])       r_rx_ferr  <= 1'b0;
         case (r_rx_state)
            S_IDLE: begin
               if (!r_rx_s2) begin
                  r_rx_state <= S_START;
                  r_rx_cnt   <= '0;
                  r_rx_div   <= eff_div(r_divisor);
               end
            end
            S_START: begin
               if (w_rx_half) begin
                  r_rx_cnt   <= '0;
                  r_rx_bit   <= '0;
                  r_rx_div   <= eff_div(r_divisor);
                  r_rx_state <= r_rx_s2 ? S_IDLE : S_DATA;   // high at mid-start = glitch
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (w_rx_done) begin
                  r_rx_cnt   <= '0;
                  r_rx_div   <= eff_div(r_divisor);
                  r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                  r_rx_bit   <= r_rx_bit + 3'd1;
                  if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
            default: begin
               if (w_rx_done) begin
                  r_rx_cnt   <= '0;
                  r_rx_state <= S_IDLE;
                  if (!r_rx_s2) begin
                     r_rx_ferr <= 1'b1;
                  end else if (!r_rx_valid || w_rx_pop) begin
                     r_rx_byte  <= r_rx_shift;
                     r_rx_valid <= 1'b1;
                  end else begin
                     r_rx_ovr <= 1'b1;
                  end
               end else begin
                  r_rx_cnt <= r_rx_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   // ---------------- read path ----------------
   always_comb begin
      w_status              = '0;
      w_status[ST_TX_FULL]  = w_full;
      w_status[ST_TX_EMPTY] = w_empty;
      w_status[ST_RX_VALID] = r_rx_valid;
      w_status[ST_RX_OVR]   = r_rx_ovr;
      w_status[ST_TX_OVF]   = r_tx_ovf;
      w_status[ST_TX_BUSY]  = (r_tx_state != S_IDLE);
      w_status[ST_RX_FERR]  = r_rx_ferr;
      w_status[12:8]        = 5'(w_count);
      w_rdata               = '0;
      if (w_hit) begin
         case (w_off)
            REG_DATA:    w_rdata = {r_rx_valid, 23'b0, r_rx_byte};
            REG_STATUS:  w_rdata = w_status;
            REG_DIVISOR: w_rdata = {16'b0, r_divisor};
            default:     w_rdata = '0;
         endcase
      end
   end

   assign rdata   = w_rdata;
   assign hit     = w_hit;
   assign uart_tx = r_uart_tx;

endmodule

// File: tb/tb_bus_uart.sv
// tb/tb_bus_uart.sv - self-checking bench for bus_uart with a frame-level UART model
module tb_bus_uart;

   localparam logic [31:0] BASE = 32'h0C00_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] bus_addr = BASE;
   logic [31:0] bus_data_w = '0;
   logic [3:0]  bus_mask_w = '0;
   logic        bus_write = 1'b0;
   logic [31:0] rdata;
   logic        hit;
   logic        uart_tx;
   logic        uart_rx = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [7:0] tx_got[$];
   logic       m_valid = 0, m_ovr = 0, m_ferr = 0;
   logic [7:0] m_byte = 0;
   logic [15:0] m_div = 16'd434;

   bus_uart dut (
      .clock(clock), .reset(reset), .bus_addr(bus_addr), .bus_data_w(bus_data_w),
      .bus_mask_w(bus_mask_w), .bus_write(bus_write), .rdata(rdata), .hit(hit),
      .uart_tx(uart_tx), .uart_rx(uart_rx)
   );

   always #5 clock = ~clock;

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] rx_bits();
      return {25'b0, m_ferr, 1'b0, 1'b0, m_ovr, m_valid, 2'b0};
   endfunction

   function automatic logic [31:0] exp_data();
      return {m_valid, 23'b0, m_byte};
   endfunction

   function automatic void m_frame(input logic [7:0] b, input logic stop);
      if (!stop)          m_ferr = 1;
      else if (!m_valid)  begin m_byte = b; m_valid = 1; end
      else                m_ovr = 1;
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic bus_wr_a(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
      @(posedge clock); #1;
      bus_addr = addr; bus_data_w = data; bus_mask_w = mask; bus_write = 1'b1;
      @(posedge clock); #1;
      bus_write = 1'b0; bus_mask_w = '0;
   endtask

   task automatic bus_wr(input logic [1:0] off, input logic [31:0] data, input logic [3:0] mask);
      bus_wr_a(BASE + 32'(off), data, mask);
   endtask

   task automatic bus_rd_a(input logic [31:0] addr, output logic [31:0] d, output logic h);
      bus_addr = addr; #1; d = rdata; h = hit;
   endtask

   task automatic bus_rd(input logic [1:0] off, output logic [31:0] d);
      logic h;
      bus_rd_a(BASE + 32'(off), d, h);
   endtask

   task automatic set_div(input logic [15:0] d);
      bus_wr(2'd2, {16'b0, d}, 4'b0011);
      m_div = d;
   endtask

   task automatic collect_tx(input int n, input int d);
      logic prev; int budget; logic [7:0] b;
      tx_got.delete(); prev = uart_tx; budget = 0; b = '0;
      while (tx_got.size() < n && budget < 20000) begin
         cyc(1); budget++;
         if (prev && !uart_tx) begin
            cyc(d / 2);
            for (int i = 0; i < 8; i++) begin cyc(d); b[i] = uart_tx; end
            cyc(d);
            checks++;
            if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_stop_bit: got %b want 1", uart_tx); end
            tx_got.push_back(b);
            budget += 10 * d;
         end
         prev = uart_tx;
      end
      checks++;
      if (tx_got.size() != n) begin
         errors++; $display("FAIL tx_collect_count: got %0d frames want %0d", tx_got.size(), n);
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin uart_rx = fr[i]; cyc(d); end
      uart_rx = 1'b1;
      cyc(2 * d);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b0; cyc(3);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
      bus_rd(2'd1, d);
      checks++; if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h want 00000002", d); end
      bus_rd(2'd2, d);
      checks++; if (d !== 32'd434) begin errors++; $display("FAIL reset_div: got %0d want 434", d); end
      bus_rd(2'd0, d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", d); end
      reset = 1'b1; cyc(2);
   endtask

   task automatic test_tx_timing(input logic [7:0] b, input logic [15:0] dw);
      int de; logic [9:0] fr; logic exp_tx, exp_busy;
      de = (dw < 4) ? 4 : int'(dw);
      fr = {1'b1, b, 1'b0};
      set_div(dw);
      bus_wr(2'd0, {24'b0, b}, 4'b0001);
      bus_addr = BASE + 32'd1;
      for (int k = 1; k <= 10 * de + 1; k++) begin
         cyc(1);
         exp_tx   = (k > 10 * de) ? 1'b1 : fr[(k - 1) / de];
         exp_busy = (k <= 10 * de);
         checks++;
         if (uart_tx !== exp_tx) begin
            errors++; $display("FAIL tx_wave byte=%h d=%0d cycle=%0d: got %b want %b", b, de, k, uart_tx, exp_tx);
         end
         checks++;
         if (rdata[5] !== exp_busy) begin
            errors++; $display("FAIL tx_busy cycle=%0d: got %b want %b", k, rdata[5], exp_busy);
         end
      end
   endtask

   task automatic test_tx_stream();
      logic [7:0] exp_q[$]; logic [31:0] d;
      set_div(16'd4);
      for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom));
      fork
         collect_tx(6, 4);
         for (int i = 0; i < 6; i++) bus_wr(2'd0, {24'b0, exp_q[i]}, 4'b0001);
      join
      for (int i = 0; i < 6 && i < tx_got.size(); i++) begin
         checks++;
         if (tx_got[i] !== exp_q[i]) begin errors++; $display("FAIL tx_stream[%0d]: got %h want %h", i, tx_got[i], exp_q[i]); end
      end
      cyc(8);
      bus_rd(2'd1, d);
      checks++; if (d !== (32'h2 | rx_bits())) begin errors++; $display("FAIL tx_stream_idle: got %h want %h", d, 32'h2 | rx_bits()); end
   endtask

   task automatic test_tx_overflow();
      logic [7:0] mq[$]; logic ovf; logic [31:0] d, e;
      ovf = 0;
      set_div(16'd256);
      bus_wr(2'd0, 32'h00, 4'b0001);            // taken by the idle transmitter at once
      for (int i = 0; i <= 16; i++) begin
         bus_wr(2'd0, 32'(i), 4'b0001);
         if (mq.size() < 16) mq.push_back(8'(i)); else ovf = 1;
      end
      e = (32'(mq.size()) << 8) | 32'h20 | (32'(ovf) << 4) | ((mq.size() == 16) ? 32'h1 : 32'h0) | rx_bits();
      bus_rd(2'd1, d);
      checks++; if (d !== e) begin errors++; $display("FAIL tx_full_status: got %h want %h", d, e); end
      set_div(16'd4);
      collect_tx(16, 4);
      for (int i = 0; i < 16 && i < tx_got.size(); i++) begin
         checks++;
         if (tx_got[i] !== mq[i]) begin errors++; $display("FAIL tx_ovf_byte[%0d]: got %h want %h", i, tx_got[i], mq[i]); end
      end
      cyc(60);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL tx_no_extra: got %b want 1", uart_tx); end
      bus_rd(2'd1, d);
      e = 32'h12 | rx_bits();
      checks++; if (d !== e) begin errors++; $display("FAIL tx_drain_status: got %h want %h", d, e); end
      bus_wr(2'd1, 32'h10, 4'b0001);
      bus_rd(2'd1, d);
      checks++; if (d !== (32'h2 | rx_bits())) begin errors++; $display("FAIL tx_ovf_clear: got %h want %h", d, 32'h2 | rx_bits()); end
   endtask

   task automatic test_rx_basic();
      logic [31:0] d;
      set_div(16'd4);
      send_rx(8'hA3, 1'b1, 4); m_frame(8'hA3, 1'b1);
      bus_rd(2'd0, d);
      checks++; if (d !== exp_data()) begin errors++; $display("FAIL rx_a3: got %h want %h", d, exp_data()); end
      bus_wr(2'd1, 32'h4, 4'b0001); m_valid = 0;
      bus_rd(2'd0, d);
      checks++; if (d !== exp_data()) begin errors++; $display("FAIL rx_pop: got %h want %h", d, exp_data()); end
   endtask

   task automatic test_rx_errors();
      logic [31:0] d; logic [7:0] b;
      send_rx(8'h11, 1'b1, 4); m_frame(8'h11, 1'b1);
      send_rx(8'h22, 1'b1, 4); m_frame(8'h22, 1'b1);
      bus_rd(2'd0, d);
      checks++; if (d !== exp_data()) begin errors++; $display("FAIL rx_ovr_data: got %h want %h", d, exp_data()); end
      bus_rd(2'd1, d);
      checks++; if (d !== (32'h2 | rx_bits())) begin errors++; $display("FAIL rx_ovr_status: got %h want %h", d, 32'h2 | rx_bits()); end
      bus_wr(2'd1, 32'h0C, 4'b0001); m_valid = 0; m_ovr = 0;
      uart_rx = 1'b0; cyc(1); uart_rx = 1'b1; cyc(20);
      bus_rd(2'd1, d);
      checks++; if (d !== (32'h2 | rx_bits())) begin errors++; $display("FAIL rx_glitch: got %h want %h", d, 32'h2 | rx_bits()); end
      b = 8'($urandom);
      send_rx(b, 1'b1, 4); m_frame(b, 1'b1);
      b = 8'($urandom);
      send_rx(b, 1'b0, 4); m_frame(b, 1'b0);
      bus_rd(2'd0, d);
      checks++; if (d !== exp_data()) begin errors++; $display("FAIL rx_ferr_data: got %h want %h", d, exp_data()); end
      bus_rd(2'd1, d);
      checks++; if (d !== (32'h2 | rx_bits())) begin errors++; $display("FAIL rx_ferr_status: got %h want %h", d, 32'h2 | rx_bits()); end
      bus_wr(2'd1, 32'h4C, 4'b0001); m_valid = 0; m_ovr = 0; m_ferr = 0;
   endtask

   task automatic test_rx_random();
      logic [31:0] d; logic [7:0] b; logic stop; int dv;
      for (int it = 0; it < 8; it++) begin
         dv = 4 + int'($urandom_range(0, 4));
         set_div(16'(dv));
         b = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         send_rx(b, stop, dv); m_frame(b, stop);
         bus_rd(2'd0, d);
         checks++; if (d !== exp_data()) begin errors++; $display("FAIL rx_rand_data[%0d]: got %h want %h", it, d, exp_data()); end
         bus_rd(2'd1, d);
         checks++; if (d !== (32'h2 | rx_bits())) begin errors++; $display("FAIL rx_rand_status[%0d]: got %h want %h", it, d, 32'h2 | rx_bits()); end
         if ($urandom_range(0, 1) == 1) begin bus_wr(2'd1, 32'h4, 4'b0001); m_valid = 0; end
      end
      bus_wr(2'd1, 32'h4C, 4'b0001); m_valid = 0; m_ovr = 0; m_ferr = 0;
   endtask

   task automatic test_window();
      logic [31:0] d, a; logic h;
      logic [31:0] outs[4];
      bus_rd_a(BASE + 32'd3, d, h);
      checks++; if (d !== 32'h0 || h !== 1'b1) begin errors++; $display("FAIL reg3_read: got %h hit=%b want 0 hit=1", d, h); end
      outs[0] = BASE + 32'd4; outs[1] = BASE - 32'd1; outs[2] = BASE ^ 32'h8000_0000;
      outs[3] = BASE ^ (32'($urandom_range(1, 255)) << 2);
      for (int i = 0; i < 4; i++) begin
         bus_rd_a(outs[i], d, h);
         checks++; if (h !== 1'b0 || d !== 32'h0) begin errors++; $display("FAIL miss_read[%0d]: got hit=%b rdata=%h want 0 0", i, h, d); end
      end
      a = BASE + 32'd4 + 32'd2;
      bus_wr_a(a, 32'h1234, 4'b1111);
      bus_wr_a(BASE + 32'd4, 32'h99, 4'b1111);
      bus_rd(2'd2, d);
      checks++; if (d !== {16'b0, m_div}) begin errors++; $display("FAIL miss_write_div: got %h want %h", d, m_div); end
      bus_wr(2'd0, 32'h77, 4'b1110);
      cyc(2);
      bus_rd(2'd1, d);
      checks++; if (d !== (32'h2 | rx_bits())) begin errors++; $display("FAIL masked_data_write: got %h want %h", d, 32'h2 | rx_bits()); end
      bus_wr(2'd2, 32'hABCD, 4'b0001); m_div[7:0] = 8'hCD;
      bus_rd(2'd2, d);
      checks++; if (d !== {16'b0, m_div}) begin errors++; $display("FAIL div_lane0: got %h want %h", d, m_div); end
      bus_wr(2'd2, 32'h5E00, 4'b0010); m_div[15:8] = 8'h5E;
      bus_rd(2'd2, d);
      checks++; if (d !== {16'b0, m_div}) begin errors++; $display("FAIL div_lane1: got %h want %h", d, m_div); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] d;
      set_div(16'd4);
      bus_wr(2'd0, {24'b0, 8'($urandom)}, 4'b0001);
      cyc(18);
      reset = 1'b0; #1;
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midframe_tx: got %b want 1", uart_tx); end
      bus_rd(2'd1, d);
      checks++; if (d !== 32'h2) begin errors++; $display("FAIL midframe_status: got %h want 00000002", d); end
      bus_rd(2'd2, d);
      checks++; if (d !== 32'd434) begin errors++; $display("FAIL midframe_div: got %0d want 434", d); end
      cyc(2); reset = 1'b1; m_div = 16'd434;
      m_valid = 0; m_ovr = 0; m_ferr = 0; m_byte = 0;
      cyc(50);
      checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL midframe_abandon: got %b want 1", uart_tx); end
   endtask

   initial begin
      test_reset();
      test_tx_timing(8'h55, 16'd4);
      test_tx_timing(8'($urandom), 16'(5 + $urandom_range(0, 3)));
      test_tx_timing(8'($urandom), 16'd2);
      test_tx_stream();
      test_tx_overflow();
      test_rx_basic();
      test_rx_errors();
      test_rx_random();
      test_window();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
